// File: rtl/router_1_arbiter_if.sv
// ----------------------------------------------------------------------------
// router_1_arbiter_if
//   Bundle between the flow-control stage, the output-port arbiter and the
//   crossbar/output FIFO of one router output.
//
//   Requests/tails (driven by the flow-control side):
//     Lreq, Wreq, Sreq     head flit of input L/W/S is routed here and FIFO ready
//     Ltail, Wtail, Stail  head flit of input L/W/S is a tail flit
//   Arbiter results (driven by the arbiter):
//     Lgrant, Wgrant, Sgrant  registered one-hot (or all-zero) grant
//     sel                     crossbar select: 00 L, 01 W, 10 S, 11 none
//     wr_en                   output-FIFO write strobe (combinational)
//     busy                    a packet currently holds the output
//
//   Handshake: a flit moves from input X in exactly the cycles where Xgrant=1
//   and Xreq=1 on the same rising edge; wr_en marks those cycles. Xreq may
//   drop at any time without losing the grant, and Xtail is only meaningful
//   in a transfer cycle.
// ----------------------------------------------------------------------------
interface router_1_arbiter_if;
    logic       Lreq;
    logic       Wreq;
    logic       Sreq;
    logic       Ltail;
    logic       Wtail;
    logic       Stail;
    logic       Lgrant;
    logic       Wgrant;
    logic       Sgrant;
    logic [1:0] sel;
    logic       wr_en;
    logic       busy;

    // Flow-control side: raises requests, observes the arbiter's decisions.
    modport master (
        output Lreq, Wreq, Sreq, Ltail, Wtail, Stail,
        input  Lgrant, Wgrant, Sgrant, sel, wr_en, busy
    );

    // Arbiter side.
    modport slave (
        input  Lreq, Wreq, Sreq, Ltail, Wtail, Stail,
        output Lgrant, Wgrant, Sgrant, sel, wr_en, busy
    );
endinterface

// File: rtl/router_1_arbiter.sv
// ----------------------------------------------------------------------------
// router_1_arbiter
//   Wormhole round-robin arbiter for one router output port shared by the
//   L, W and S inputs. A grant is issued from IDLE to the first requester
//   after the last-served port (L->W->S->L) and is held until that port
//   transfers its tail flit; then one IDLE bubble cycle follows.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        router_1_arbiter_if.slave (requests, tails, grants, sel,
//                wr_en, busy)
//     dbg_state  current FSM state (0 IDLE, 1 GNT_L, 2 GNT_W, 3 GNT_S)
//
//   Parameter:
//     PRIO_RST   last-served pointer after reset (0 L, 1 W, 2 S)
// ----------------------------------------------------------------------------
module router_1_arbiter #(
    parameter logic [1:0] PRIO_RST = 2'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    router_1_arbiter_if.slave     bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_L = 2'd1,
        GNT_W = 2'd2,
        GNT_S = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;          // last-served port: 0 L, 1 W, 2 S
    logic       lgrant_q, wgrant_q, sgrant_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic [2:0] req;                 // {S, W, L}
    logic       xfer_l, xfer_w, xfer_s;

    assign req = {bus.Sreq, bus.Wreq, bus.Lreq};

    // First requester strictly after 'last' in L->W->S->L order. Scanning
    // from the farthest candidate back to the nearest lets the nearest win.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] win;
        logic [1:0] cand;
        win = last;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(last) + k) % 3);
            if (r[cand]) win = cand;
        end
        return win;
    endfunction

    assign xfer_l = (state == GNT_L) && bus.Lreq;
    assign xfer_w = (state == GNT_W) && bus.Wreq;
    assign xfer_s = (state == GNT_S) && bus.Sreq;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    unique case (rr_pick(ptr, req))
                        2'd0:    state_n = GNT_L;
                        2'd1:    state_n = GNT_W;
                        default: state_n = GNT_S;
                    endcase
                end
            end
            // The grant is only released by a tail transfer of the owner;
            // other ports' requests are not looked at here.
            GNT_L: if (xfer_l && bus.Ltail) begin state_n = IDLE; ptr_n = 2'd0; end
            GNT_W: if (xfer_w && bus.Wtail) begin state_n = IDLE; ptr_n = 2'd1; end
            GNT_S: if (xfer_s && bus.Stail) begin state_n = IDLE; ptr_n = 2'd2; end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the
    // state register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= PRIO_RST;
            lgrant_q <= 1'b0;
            wgrant_q <= 1'b0;
            sgrant_q <= 1'b0;
            sel_q    <= 2'b11;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            lgrant_q <= (state_n == GNT_L);
            wgrant_q <= (state_n == GNT_W);
            sgrant_q <= (state_n == GNT_S);
            busy_q   <= (state_n != IDLE);
            unique case (state_n)
                GNT_L:   sel_q <= 2'b00;
                GNT_W:   sel_q <= 2'b01;
                GNT_S:   sel_q <= 2'b10;
                default: sel_q <= 2'b11;
            endcase
        end
    end

    assign bus.Lgrant = lgrant_q;
    assign bus.Wgrant = wgrant_q;
    assign bus.Sgrant = sgrant_q;
    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    // Reset must suppress writes even while the state register still shows
    // a grant from before the reset edge.
    assign bus.wr_en  = !rst && (xfer_l || xfer_w || xfer_s);
    assign dbg_state  = state;

endmodule

// File: tb/tb_router_1_arbiter.sv
// ----------------------------------------------------------------------------
// tb_router_1_arbiter
//   Bench for router_1_arbiter. A behavioural model tracks which port owns
//   the output (or none) and the last-served port, and every cycle's
//   grants/sel/busy/wr_en are compared against it. Directed scenarios pin
//   the model with literal expectations, then random traffic follows.
// ----------------------------------------------------------------------------
module tb_router_1_arbiter;

    localparam logic [1:0] PRIO_RST = 2'd2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    router_1_arbiter_if bus();

    router_1_arbiter #(.PRIO_RST(PRIO_RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model + scoreboard state ----------------
    int         m_owner;      // -1 none, 0 L, 1 W, 2 S
    int         m_last;       // last-served port
    int         n_cmp;
    int         n_fail;
    bit         check_en;
    logic [1:0] obs_sel;
    logic       obs_wr;
    logic [1:0] exp_q[$];     // literal sel expectations queued per scenario

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs mid-period, compare outputs against the
    // model, then advance the model across the rising edge.
    task automatic cyc(input bit r, input bit [2:0] rq, input bit [2:0] tl);
        logic [2:0] exp_gnt;
        logic [1:0] exp_sel;
        logic       exp_wr;
        @(negedge clk);
        rst       = r;
        bus.Lreq  = rq[0];
        bus.Wreq  = rq[1];
        bus.Sreq  = rq[2];
        bus.Ltail = tl[0];
        bus.Wtail = tl[1];
        bus.Stail = tl[2];
        #1;
        obs_sel = bus.sel;
        obs_wr  = bus.wr_en;
        if (check_en) begin
            exp_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            exp_sel = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
            exp_wr  = !r && (m_owner >= 0) && rq[m_owner];
            chk("grant", {5'd0, bus.Sgrant, bus.Wgrant, bus.Lgrant}, {5'd0, exp_gnt});
            chk("sel",   {6'd0, bus.sel},   {6'd0, exp_sel});
            chk("busy",  {7'd0, bus.busy},  {7'd0, m_owner >= 0});
            chk("wr_en", {7'd0, bus.wr_en}, {7'd0, exp_wr});
        end
        @(posedge clk);
        if (r) begin
            m_owner = -1;
            m_last  = PRIO_RST;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                if (m_owner < 0 && rq[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
            end
        end else if (rq[m_owner] && tl[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        check_en = 1'b1;
    endtask

    // Run one cycle and pin the observed sel/wr_en to literal values.
    task automatic cyc_lit(input string name, input bit [2:0] rq, input bit [2:0] tl,
                           input logic [1:0] lit_sel, input logic lit_wr);
        cyc(1'b0, rq, tl);
        chk({name, "_sel"}, {6'd0, obs_sel}, {6'd0, lit_sel});
        chk({name, "_wr"},  {7'd0, obs_wr},  {7'd0, lit_wr});
    endtask

    task automatic do_reset();
        cyc(1'b1, 3'b000, 3'b000);
        cyc(1'b1, 3'b111, 3'b111);   // requests during reset must not write
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        check_en = 1'b0;
        m_owner  = -1;
        m_last   = PRIO_RST;
        rst      = 1'b1;
        {bus.Lreq, bus.Wreq, bus.Sreq}    = 3'b000;
        {bus.Ltail, bus.Wtail, bus.Stail} = 3'b000;

        // Reset state, then 10 idle cycles.
        do_reset();
        for (int i = 0; i < 10; i++) cyc_lit("idle", 3'b000, 3'b000, 2'b11, 1'b0);

        // All ports requesting single-flit packets: L, W, S, L with bubbles.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
        while (exp_q.size() > 0) begin
            logic [1:0] s;
            s = exp_q.pop_front();
            cyc_lit("rr", 3'b111, 3'b111, s, s != 2'b11);
        end

        // 4-flit W packet, L requests from the 2nd flit; L waits for IDLE.
        do_reset();
        cyc_lit("w_req",  3'b010, 3'b000, 2'b11, 1'b0);
        cyc_lit("w_f1",   3'b010, 3'b000, 2'b01, 1'b1);
        cyc_lit("w_f2",   3'b011, 3'b000, 2'b01, 1'b1);
        cyc_lit("w_f3",   3'b011, 3'b001, 2'b01, 1'b1);
        cyc_lit("w_f4",   3'b011, 3'b011, 2'b01, 1'b1);
        cyc_lit("w_bub",  3'b001, 3'b000, 2'b11, 1'b0);
        cyc_lit("l_gnt",  3'b001, 3'b001, 2'b00, 1'b1);
        cyc_lit("l_done", 3'b000, 3'b000, 2'b11, 1'b0);

        // S stalls 3 cycles mid-packet while L requests: no switch.
        do_reset();
        cyc_lit("s_req",  3'b100, 3'b000, 2'b11, 1'b0);
        cyc_lit("s_f1",   3'b100, 3'b000, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) cyc_lit("s_stall", 3'b001, 3'b111, 2'b10, 1'b0);
        cyc_lit("s_tail", 3'b101, 3'b100, 2'b10, 1'b1);
        cyc_lit("s_bub",  3'b001, 3'b000, 2'b11, 1'b0);
        cyc_lit("l_aft",  3'b001, 3'b001, 2'b00, 1'b1);

        // Last served L, then L and S request: S wins.
        do_reset();
        cyc_lit("pl_req", 3'b001, 3'b001, 2'b11, 1'b0);
        cyc_lit("pl_gnt", 3'b001, 3'b001, 2'b00, 1'b1);
        cyc_lit("pl_bub", 3'b101, 3'b000, 2'b11, 1'b0);
        cyc_lit("ps_gnt", 3'b101, 3'b000, 2'b10, 1'b1);

        // Reset in the middle of a W packet, then L beats W.
        do_reset();
        cyc_lit("rw_req", 3'b010, 3'b000, 2'b11, 1'b0);
        cyc_lit("rw_f1",  3'b010, 3'b000, 2'b01, 1'b1);
        cyc(1'b1, 3'b010, 3'b000);
        cyc_lit("rw_rst", 3'b011, 3'b000, 2'b11, 1'b0);
        cyc_lit("rw_l",   3'b011, 3'b000, 2'b00, 1'b1);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit [2:0] rq;
            bit [2:0] tl;
            rq = 3'($urandom_range(0, 7));
            tl = 3'($urandom_range(0, 7));
            // Bias tails low so multi-flit packets and stalls appear.
            if ($urandom_range(0, 2) != 0) tl = 3'b000;
            cyc($urandom_range(0, 99) == 0, rq, tl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/router_1_arbiter.md
ROUTER_1_ARBITER -- requirements
Module: router_1_arbiter

Interface
REQ-001 Parameter: PRIO_RST, default 2'd2, last-served pointer value after reset (0=L, 1=W, 2=S), so L has first priority.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 Lreq, Wreq, Sreq  input  1 each  flow-qualified request from the flowcontrol stage (input port X has a head flit routed here and the output FIFO is ready).
REQ-005 Ltail, Wtail, Stail  input  1 each  head flit of input X is a tail flit; sampled only on a transfer from X.
REQ-006 Lgrant, Wgrant, Sgrant  output  1 each  registered grant, one-hot or all-zero.
REQ-007 sel  output  2  registered crossbar select: 00 L, 01 W, 10 S, 11 none.
REQ-008 wr_en  output  1  output-FIFO write strobe, combinational.
REQ-009 busy  output  1  registered, high while a packet holds the output.

Function
REQ-010 FSM states: IDLE, GNT_L, GNT_W, GNT_S; grant outputs and sel decode directly from state.
REQ-011 IDLE: no grant, sel=11, busy=0.
REQ-012 GNT_X: Xgrant=1, other grants 0, sel per REQ-007, busy=1.
REQ-013 Transfer from X occurs in a cycle iff state=GNT_X and Xreq=1.
REQ-014 wr_en = 1 exactly in transfer cycles; otherwise 0; never asserted in IDLE.
REQ-015 IDLE with any request: move to GNT_X next cycle, X = first requester in round-robin order starting after the last-served port (order L->W->S->L).
REQ-016 IDLE with no request: remain IDLE.
REQ-017 GNT_X with a transfer and Xtail=1: go to IDLE next cycle and set last-served pointer to X.
REQ-018 GNT_X without a tail transfer (including Xreq=0): hold GNT_X; grant is never revoked mid-packet (wormhole lock).
REQ-019 Requests from non-granted ports while in GNT_X are ignored; they are not latched.
REQ-020 Last-served pointer is updated only on a tail transfer, never on grant issue.
REQ-021 Grant latency: first request in IDLE at cycle n gives grant at n+1, first possible transfer at n+1.
REQ-022 Packet turnaround: tail transfer at cycle n gives IDLE at n+1 and next grant at n+2 (one bubble cycle, fixed).
REQ-023 Single-flit packet (head with tail=1): one transfer, then IDLE.
REQ-024 Tail inputs are ignored in IDLE and in cycles without a transfer.

Reset
REQ-025 When rst=1 at a clock edge: state=IDLE, pointer=PRIO_RST, all grants=0, sel=11, busy=0.
REQ-026 While rst=1, wr_en=0 regardless of requests.
REQ-027 Reset mid-packet aborts the lock immediately; no state is retained.
REQ-028 First arbitration occurs on the first edge with rst=0.

Verification
REQ-029 After reset, Lreq=Wreq=Sreq=1 held with all tails=1 -> grants cycle L, W, S, L, each for 1 cycle separated by 1 IDLE cycle; wr_en pulses on each grant cycle.
REQ-030 Wreq=1 for 4 cycles, Wtail=1 only on cycle 4, with Lreq=1 raised at cycle 2 -> Wgrant held for 4 transfers; Lgrant only after IDLE; sel=01 then 11 then 00.
REQ-031 In GNT_S, Sreq drops for 3 cycles mid-packet while Lreq=1 -> Sgrant stays high, wr_en=0 for those 3 cycles, no switch to L.
REQ-032 Pointer=L (last served L), then Lreq=1 and Sreq=1 -> S is granted before L.
REQ-033 rst=1 asserted while in GNT_W mid-packet -> next cycle all grants=0, sel=11, busy=0; after release with Lreq=1 and Wreq=1, L is granted first (PRIO_RST=2).
REQ-034 No requests for 10 cycles after reset -> state IDLE throughout, wr_en=0, sel=11.
